rgb_led_pwm_driver: RTL and testbench

- Downstream stage of the 2-bit magnitude comparator that drives the board RGB LED.
- The comparator outputs R (a>=b), G (a<=b) and B (a!=b) are combinational and follow raw switch inputs, so they are asynchronous, bouncy, and drive the LED at full brightness.
- This block synchronises the three colour requests and filters them for stability.
- It then drives each LED channel with a shared, brightness-controlled PWM, updating only on PWM period boundaries.

---
 rtl/rgb_led_pwm_driver.sv | 112 +++++++++++
 tb/tb_rgb_led_pwm_driver.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_led_pwm_driver.sv
// rtl/rgb_led_pwm_driver.sv - synchronised, debounced, PWM-dimmed RGB LED driver
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   en            driver enable; low blanks LEDs and halts the PWM counter
//   r_in/g_in/b_in asynchronous colour requests from the comparator
//   duty          brightness, sampled only at a PWM period boundary
//   led_r/g/b     LED drives, active high
//   period_start  one-cycle pulse on the first cycle of each PWM period
module rgb_led_pwm_driver #(
    parameter int CNT_W         = 8,
    parameter int STABLE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             r_in,
    input  logic             g_in,
    input  logic             b_in,
    input  logic [CNT_W-1:0] duty,
    output logic             led_r,
    output logic             led_g,
    output logic             led_b,
    output logic             period_start
);

    localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [RUN_W-1:0] RUN_TGT = RUN_W'(STABLE_CYCLES);

    // Colour vectors are ordered {r, g, b}.
    logic [2:0]       sync1;
    logic [2:0]       s;
    logic [2:0]       cand;
    logic [2:0]       applied;
    logic [2:0]       en_q;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_next;
    logic [CNT_W-1:0] pwm_cnt;
    logic [CNT_W-1:0] duty_q;
    logic             on_phase;

    // run is the length of the current streak of identical samples,
    // including the sample being taken this cycle. A new value loads the
    // candidate with a streak of one; the request is accepted on the edge
    // where the streak reaches STABLE_CYCLES, so a pulse of exactly
    // STABLE_CYCLES post-sync cycles is accepted and anything shorter is not.
    always_comb begin
        run_next = run;
        if (s != cand) begin
            run_next = RUN_W'(1);
        end else if (run < RUN_TGT) begin
            run_next = run + RUN_W'(1);
        end
    end

    // Synchroniser and stability filter; runs regardless of en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= '0;
            s       <= '0;
            cand    <= '0;
            run     <= '0;
            applied <= '0;
        end else begin
            sync1 <= {r_in, g_in, b_in};
            s     <= sync1;
            cand  <= s;
            run   <= run_next;
            // Once saturated this re-writes the same value every cycle.
            if (run_next == RUN_TGT) begin
                applied <= s;
            end
        end
    end

    // PWM counter with period-boundary sampling of duty and colour mask.
    // Latching only at the boundary keeps every pulse whole: mid-period
    // changes wait for the next period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt      <= '0;
            duty_q       <= '0;
            en_q         <= '0;
            period_start <= 1'b0;
        end else begin
            period_start <= 1'b0;
            if (!en) begin
                pwm_cnt <= '0;
                en_q    <= '0;
            end else begin
                pwm_cnt <= pwm_cnt + CNT_W'(1);
                if (pwm_cnt == CNT_MAX) begin
                    duty_q       <= duty;
                    en_q         <= applied;
                    period_start <= 1'b1;
                end
            end
        end
    end

    // All-ones duty means fully on rather than (2^CNT_W-1)/2^CNT_W, so the
    // LED has no dark cycle at the wrap.
    assign on_phase = (duty_q == CNT_MAX) || (pwm_cnt < duty_q);

    // en is gated combinationally so dropping it blanks the LEDs at once.
    assign led_r = en & en_q[2] & on_phase;
    assign led_g = en & en_q[1] & on_phase;
    assign led_b = en & en_q[0] & on_phase;

endmodule

// File: tb/tb_rgb_led_pwm_driver.sv
// tb/tb_rgb_led_pwm_driver.sv - self-checking bench for rgb_led_pwm_driver
module tb_rgb_led_pwm_driver;

    localparam int CW   = 4;
    localparam int STAB = 4;
    localparam int PER  = 1 << CW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          r_in = 1'b0;
    logic          g_in = 1'b0;
    logic          b_in = 1'b0;
    logic [CW-1:0] duty = '0;
    logic          led_r;
    logic          led_g;
    logic          led_b;
    logic          period_start;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: PWM position, latched duty/colour mask,
    // accepted colour, boundary pulse, and history of raw input samples.
    int         m_pos;
    int         m_duty;
    logic [2:0] m_mask;
    logic [2:0] m_app;
    logic       m_ps;
    logic [2:0] raw[$];

    rgb_led_pwm_driver #(.CNT_W(CW), .STABLE_CYCLES(STAB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .r_in         (r_in),
        .g_in         (g_in),
        .b_in         (b_in),
        .duty         (duty),
        .led_r        (led_r),
        .led_g        (led_g),
        .led_b        (led_b),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pos  = 0;
        m_duty = 0;
        m_mask = 3'b000;
        m_app  = 3'b000;
        m_ps   = 1'b0;
        raw.delete();
        for (int i = 0; i < 8; i++) raw.push_back(3'b000);
    endtask

    // One rising edge of the model. The filter sees each raw sample two
    // edges late; a colour is accepted once the last STAB filter samples agree.
    task automatic model_edge();
        logic [2:0] f;
        bit         steady;
        bit         bnd;
        bnd = en && (m_pos == PER - 1);
        raw.push_back({r_in, g_in, b_in});
        if (raw.size() > 8) void'(raw.pop_front());
        f = raw[raw.size() - 3];
        steady = 1'b1;
        for (int i = 3; i < 3 + STAB; i++)
            if (raw[raw.size() - i] != f) steady = 1'b0;
        if (bnd) begin
            m_duty = int'(duty);
            m_mask = m_app;
        end
        if (steady) m_app = f;
        if (!en) begin
            m_pos  = 0;
            m_mask = 3'b000;
        end else begin
            m_pos = (m_pos + 1) % PER;
        end
        m_ps = bnd;
    endtask

    function automatic logic [2:0] exp_leds();
        bit lit;
        lit = (m_duty == PER - 1) || (m_pos < m_duty);
        return (en && lit) ? m_mask : 3'b000;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic expv);
        n_tests++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic check();
        logic [2:0] e;
        e = exp_leds();
        chk("led_r", led_r, e[2]);
        chk("led_g", led_g, e[1]);
        chk("led_b", led_b, e[0]);
        chk("period_start", period_start, m_ps);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check();
        end
    endtask

    task automatic run_until_pos(input int p);
        int n;
        n = 0;
        while (m_pos != p && n < 2 * PER) begin
            step(1);
            n++;
        end
        n_tests++;
        assert (m_pos == p)
        else begin
            n_fail++;
            $error("FAIL wait_pos observed=%0d expected=%0d", m_pos, p);
        end
    endtask

    // Asynchronous reset asserted between edges: outputs must clear at once.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_led_r", led_r, 1'b0);
        chk("rst_led_g", led_g, 1'b0);
        chk("rst_led_b", led_b, 1'b0);
        chk("rst_period_start", period_start, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        model_reset();
        @(negedge clk);
        do_reset();

        // Enabled, nothing requested: LEDs dark, boundary pulses every 16.
        en = 1'b1;
        step(20);

        // Red at duty 5.
        duty = 5;
        r_in = 1'b1;
        step(60);

        // Reset while red is lit; no period_start until the first wrap.
        n = 0;
        while (exp_leds() != 3'b100 && n < 2 * PER) begin
            step(1);
            n++;
        end
        chk("red_lit_before_reset", led_r, 1'b1);
        do_reset();
        step(40);

        // Green glitch of 3 cycles is rejected.
        g_in = 1'b1; step(3);
        g_in = 1'b0; step(30);
        // 4-cycle pulse is accepted, then a 3-cycle drop is rejected.
        g_in = 1'b1; step(4);
        g_in = 1'b0; step(3);
        g_in = 1'b1; step(40);

        // Duty extremes on blue.
        r_in = 1'b0; g_in = 1'b0; b_in = 1'b1;
        duty = 0;  step(50);
        duty = 15; step(60);

        // Mid-period duty change 5 -> 12.
        duty = 5; step(20);
        run_until_pos(3);
        duty = 12; step(40);
        // Mid-period colour change.
        run_until_pos(3);
        r_in = 1'b1; b_in = 1'b0; step(40);

        // en dropped while red is lit at pwm_cnt 2, then re-raised.
        duty = 5;
        step(20);
        run_until_pos(2);
        en = 1'b0;
        #1;
        chk("en_drop_led_r", led_r, 1'b0);
        step(5);
        en = 1'b1;
        step(40);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                r_in = 1'($urandom);
                g_in = 1'($urandom);
                b_in = 1'($urandom);
            end
            if ($urandom_range(0, 31) == 0) begin
                case ($urandom_range(0, 3))
                    0:       duty = 0;
                    1:       duty = 4'hF;
                    default: duty = CW'($urandom);
                endcase
            end
            if ($urandom_range(0, 99) == 0) begin
                en = ~en;
                #1;
                check();
            end
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end
            step(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
